// File: rtl/spi_phase_loader.sv
// rtl/spi_phase_loader.sv - SPI byte-frame loader for a double-buffered transducer phase table
//
// Frames are SYNC(0xA5), ADDR, DATA, and also CHK when PHASE_LOADER_CHECKSUM_EN is defined.
// ADDR < NUM_CH writes DATA into the shadow table. ADDR = 0xFF copies shadow to active.
// Any other ADDR, a bad CHK, an ss rise mid-frame, or an inter-byte timeout rejects the frame.
//
// Ports:
//   clk, rst (async active-low, deassertion synchronized)
//   ss          - synchronized slave select, high = deselected
//   byte_valid  - one-cycle strobe qualifying byte_in
//   byte_in     - received byte
//   rd_addr     - read index into the active table
//   rd_data     - registered active[rd_addr], 0x00 when out of range
//   commit      - one-cycle pulse when shadow is copied to active
//   frame_err   - one-cycle pulse on any frame rejection
//   err_cnt     - saturating rejection count
//   busy        - state machine not idle
// Optional feature macro: PHASE_LOADER_CHECKSUM_EN (adds the CHK byte and its check)

module spi_phase_loader #(
    parameter int NUM_CH      = 64,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ss,
    input  logic                        byte_valid,
    input  logic [7:0]                  byte_in,
    input  logic [$clog2(NUM_CH)-1:0]   rd_addr,
    output logic [7:0]                  rd_data,
    output logic                        commit,
    output logic                        frame_err,
    output logic [7:0]                  err_cnt,
    output logic                        busy
);

    localparam int AW = $clog2(NUM_CH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] COMMIT_ADDR = 8'hFF;

`ifdef PHASE_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_CHK} state_t;
    localparam state_t ST_LAST = ST_CHK;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;
    localparam state_t ST_LAST = ST_DATA;
`endif

    // Reset asserts immediately but releases only after two clk edges.
    logic rst_meta;
    logic rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    state_t          state;
    logic [7:0]      addr_q;
    logic [TW-1:0]   tmo_cnt;
    logic            ss_q;
    logic [7:0]      shadow [NUM_CH];
    logic [7:0]      active [NUM_CH];

    logic [7:0]      fin_data;
    logic            fin_ok;

`ifdef PHASE_LOADER_CHECKSUM_EN
    logic [7:0]      data_q;
    assign fin_data = data_q;
    assign fin_ok   = (byte_in == (SYNC ^ addr_q ^ data_q));
`else
    assign fin_data = byte_in;
    assign fin_ok   = 1'b1;
`endif

    logic addr_in_range;
    logic ss_abort;
    logic tmo_abort;
    logic fin;
    logic reject;

    assign busy          = (state != ST_IDLE);
    assign addr_in_range = (32'(addr_q) < NUM_CH);
    // An ss rise wins over a coincident byte strobe; the byte is dropped.
    assign ss_abort      = busy && ss && !ss_q;
    assign tmo_abort     = busy && !ss_abort && !byte_valid && (tmo_cnt == TMO_LAST);
    assign fin           = !ss_abort && byte_valid && (state == ST_LAST);
    assign reject        = ss_abort || tmo_abort ||
                           (fin && (!fin_ok || (!addr_in_range && addr_q != COMMIT_ADDR)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            addr_q    <= 8'h00;
            tmo_cnt   <= '0;
            ss_q      <= 1'b1;
            commit    <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= 8'h00;
`ifdef PHASE_LOADER_CHECKSUM_EN
            data_q    <= 8'h00;
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= 8'h00;
                active[i] <= 8'h00;
            end
        end else begin
            ss_q      <= ss;
            commit    <= 1'b0;
            frame_err <= 1'b0;
            if (reject) begin
                state     <= ST_IDLE;
                tmo_cnt   <= '0;
                frame_err <= 1'b1;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end else if (fin) begin
                state   <= ST_IDLE;
                tmo_cnt <= '0;
                if (addr_q == COMMIT_ADDR) begin
                    active <= shadow;
                    commit <= 1'b1;
                end else begin
                    shadow[addr_q[AW-1:0]] <= fin_data;
                end
            end else if (byte_valid && !ss_abort) begin
                tmo_cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (byte_in == SYNC) begin
                            state <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        addr_q <= byte_in;
                        state  <= ST_DATA;
                    end
`ifdef PHASE_LOADER_CHECKSUM_EN
                    ST_DATA: begin
                        data_q <= byte_in;
                        state  <= ST_CHK;
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end else if (busy) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 8'h00;
        end else if (32'(rd_addr) < NUM_CH) begin
            rd_data <= active[rd_addr];
        end else begin
            rd_data <= 8'h00;
        end
    end

endmodule

// File: tb/tb_spi_phase_loader.sv
// tb/tb_spi_phase_loader.sv - directed self-checking bench for spi_phase_loader

module tb_spi_phase_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss;
    logic       byte_valid;
    logic [7:0] byte_in;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       commit;
    logic       frame_err;
    logic [7:0] err_cnt;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;
    int err_pulses = 0;
    int commit_pulses = 0;
    int exp_err = 0;
    int wait_cyc;

    spi_phase_loader #(.NUM_CH(64), .TIMEOUT_CYC(4096)) dut (
        .clk        (clk),
        .rst        (rst),
        .ss         (ss),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .commit     (commit),
        .frame_err  (frame_err),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) err_pulses++;
        if (commit) commit_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] chk);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(d);
`ifdef PHASE_LOADER_CHECKSUM_EN
        send_byte(chk);
`else
        if (chk == 8'h00) begin
        end
`endif
        @(negedge clk);
    endtask

    task automatic read_at(input logic [5:0] a, output logic [7:0] d);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        d = rd_data;
    endtask

    logic [7:0] rd;

    initial begin
        rst        = 1'b0;
        ss         = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        rd_addr    = 6'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_commit", {31'd0, commit}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("reset_rd_data", {24'd0, rd_data}, 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Shadow write without commit must not reach the active table.
        send_frame(8'h03, 8'h7F, 8'hD9);
        read_at(6'd3, rd);
        check("isolated_ch3", {24'd0, rd}, 32'h00);

        commit_pulses = 0;
        send_frame(8'hFF, 8'h00, 8'h5A);
        check("commit_once", commit_pulses, 1);
        read_at(6'd3, rd);
        check("committed_ch3", {24'd0, rd}, 32'h7F);
        read_at(6'd4, rd);
        check("other_ch4", {24'd0, rd}, 32'h00);
        read_at(6'd0, rd);
        check("other_ch0", {24'd0, rd}, 32'h00);

        // Junk before SYNC is discarded silently.
        err_pulses = 0;
        send_byte(8'h00);
        send_byte(8'h11);
        send_frame(8'h05, 8'h20, 8'h80);
        send_frame(8'hFF, 8'h00, 8'h5A);
        check("junk_no_err", err_pulses, 0);
        read_at(6'd5, rd);
        check("junk_ch5", {24'd0, rd}, 32'h20);
        read_at(6'd3, rd);
        check("keep_ch3", {24'd0, rd}, 32'h7F);

`ifdef PHASE_LOADER_CHECKSUM_EN
        err_pulses = 0;
        send_frame(8'h03, 8'h11, 8'h00);
        exp_err++;
        check("chk_err_pulse", err_pulses, 1);
        check("chk_err_cnt", {24'd0, err_cnt}, exp_err);
        send_frame(8'hFF, 8'h00, 8'h5A);
        read_at(6'd3, rd);
        check("chk_table_kept", {24'd0, rd}, 32'h7F);
`endif

        // Out-of-range address.
        err_pulses = 0;
        send_frame(8'h40, 8'h00, 8'hE5);
        exp_err++;
        check("range_err_pulse", err_pulses, 1);
        check("range_err_cnt", {24'd0, err_cnt}, exp_err);

        // ss rise mid-frame.
        err_pulses = 0;
        send_byte(8'hA5);
        @(negedge clk);
        ss = 1'b1;
        repeat (2) @(negedge clk);
        ss = 1'b0;
        exp_err++;
        check("ss_err_pulse", err_pulses, 1);
        check("ss_err_cnt", {24'd0, err_cnt}, exp_err);
        check("ss_busy", {31'd0, busy}, 32'd0);

        // ss high while idle does nothing.
        err_pulses = 0;
        @(negedge clk);
        ss = 1'b1;
        repeat (3) @(negedge clk);
        ss = 1'b0;
        repeat (2) @(negedge clk);
        check("ss_idle_no_err", err_pulses, 0);

        // ss rise coincident with a byte strobe: abort wins, byte dropped.
        err_pulses = 0;
        send_byte(8'hA5);
        @(negedge clk);
        byte_in    = 8'h05;
        byte_valid = 1'b1;
        ss         = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        @(negedge clk);
        ss = 1'b0;
        exp_err++;
        check("ss_vs_byte_err", err_pulses, 1);
        check("ss_vs_byte_busy", {31'd0, busy}, 32'd0);

        // Inter-byte timeout.
        err_pulses = 0;
        send_byte(8'hA5);
        check("tmo_busy_before", {31'd0, busy}, 32'd1);
        wait_cyc = 0;
        while (!frame_err && wait_cyc < 5000) begin
            @(negedge clk);
            wait_cyc++;
        end
        exp_err++;
        check("tmo_fired_in_window", {31'd0, (wait_cyc >= 4094 && wait_cyc <= 4097)}, 32'd1);
        @(negedge clk);
        check("tmo_err_pulse", err_pulses, 1);
        check("tmo_busy_after", {31'd0, busy}, 32'd0);
        check("tmo_err_cnt", {24'd0, err_cnt}, exp_err);

        // Saturate the error counter.
        for (int i = 0; i < 300; i++) begin
            send_frame(8'h40, 8'h00, 8'hE5);
        end
        check("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

        // Reset mid-frame.
        send_byte(8'hA5);
        send_byte(8'h03);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        check("rst_commit", {31'd0, commit}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        err_pulses = 0;
        send_frame(8'hFF, 8'h00, 8'h5A);
        read_at(6'd3, rd);
        check("rst_cleared_ch3", {24'd0, rd}, 32'h00);
        read_at(6'd5, rd);
        check("rst_cleared_ch5", {24'd0, rd}, 32'h00);
        check("rst_no_err", err_pulses, 0);
        check("rst_err_cnt_after", {24'd0, err_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spi_phase_loader.md
SPI_PHASE_LOADER -- requirements
Module: spi_phase_loader

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 64, giving the number of transducer phase channels (range 2..255).
REQ-002 The module SHALL have parameter TIMEOUT_CYC, default 4096, giving the maximum number of clk cycles allowed between bytes of one frame.
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock, on which all state changes on the rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port ss, input, 1 bit: the synchronized SPI slave select from the SPI slave stage; high means deselected.
REQ-006 The module SHALL have port byte_valid, input, 1 bit: a one-cycle strobe from the SPI slave stage's done output.
REQ-007 The module SHALL have port byte_in, input, 8 bits: the received byte, sampled only when byte_valid=1.
REQ-008 The module SHALL have port rd_addr, input, clog2(NUM_CH) bits: the read index into the active phase table.
REQ-009 The module SHALL have port rd_data, output, 8 bits: the active-table phase at rd_addr, registered.
REQ-010 The module SHALL have port commit, output, 1 bit: a one-cycle pulse raised when the shadow table is copied to the active table.
REQ-011 The module SHALL have port frame_err, output, 1 bit: a one-cycle pulse raised on any frame rejection.
REQ-012 The module SHALL have port err_cnt, output, 8 bits: a saturating count of frame errors.
REQ-013 The module SHALL have port busy, output, 1 bit: high whenever the state machine is not in IDLE.

Function
REQ-014 Each frame SHALL be received as SYNC(0xA5), ADDR, DATA, then CHK when checksums are enabled.
REQ-015 The state machine SHALL have states IDLE, ADDR, DATA and CHK, and SHALL advance exactly one state per byte_valid strobe.
REQ-016 In IDLE, a byte equal to 0xA5 SHALL move to ADDR; any other byte SHALL be silently discarded with no error raised.
REQ-017 An accepted write frame with ADDR < NUM_CH SHALL store DATA into shadow[ADDR] in the cycle after the final byte's strobe.
REQ-018 An accepted frame with ADDR = 0xFF SHALL copy every shadow entry into the active table in a single cycle, with DATA ignored, and SHALL pulse commit in that same cycle.
REQ-019 A frame with NUM_CH <= ADDR < 0xFF SHALL be rejected at its final byte.
REQ-020 A rejected frame SHALL leave both tables unchanged, pulse frame_err for one cycle, and return the state machine to IDLE.
REQ-021 ss rising while the state machine is not in IDLE SHALL abort the frame as a rejection.
REQ-022 ss high while in IDLE SHALL have no effect.
REQ-023 A timeout counter SHALL clear on every byte_valid and increment each cycle while busy=1.
REQ-024 The timeout counter reaching TIMEOUT_CYC SHALL abort the frame as a rejection.
REQ-025 If ss rises in the same cycle as byte_valid, the abort SHALL take priority and the byte SHALL be dropped.
REQ-026 err_cnt SHALL increment by 1 per rejection and SHALL hold at 255.
REQ-027 rd_data SHALL equal active[rd_addr] exactly 1 cycle after rd_addr is applied.
REQ-028 When a commit lands, rd_data in the following cycle SHALL show the new active value.
REQ-029 An rd_addr >= NUM_CH SHALL return rd_data = 0x00.

Reset
REQ-030 Asserting rst low SHALL immediately force IDLE, clear both tables to 0x00, and drive commit=0, frame_err=0, err_cnt=0, busy=0, rd_data=0x00 and timeout counter=0.
REQ-031 A reset asserted mid-frame SHALL discard the partial frame without counting an error.
REQ-032 Reset deassertion SHALL be synchronized to clk before it is used internally.

Configuration
REQ-033 With macro PHASE_LOADER_CHECKSUM_EN defined, frames SHALL be 4 bytes, accepted only when CHK = 0xA5 ^ ADDR ^ DATA; a mismatch SHALL be rejected.
REQ-034 Without PHASE_LOADER_CHECKSUM_EN, frames SHALL be 3 bytes, the CHK state SHALL be absent, and the action SHALL occur after the DATA byte's strobe.

Verification
REQ-035 The bench SHALL send bytes A5,03,7F,(D9) then A5,FF,00,(5A) -> commit pulses once, then rd_addr=3 gives rd_data=0x7F, and other channels read 0x00.
REQ-036 The bench SHALL send A5,03,7F without a commit -> rd_data at rd_addr=3 stays 0x00, showing the shadow table is isolated from the active table.
REQ-037 The bench SHALL send bytes 00,11,A5,05,20,(80) -> no frame_err is raised and shadow[5]=0x20 after commit.
REQ-038 With CHECKSUM_EN, the bench SHALL send A5,03,7F,00 -> frame_err pulses once, err_cnt=1, and the table is unchanged.
REQ-039 The bench SHALL send A5,40 with NUM_CH=64, and separately A5 then raise ss -> each case gives one frame_err and err_cnt increments; it SHALL also send A5 and idle for 4096 cycles -> a timeout frame_err is raised and busy falls.
REQ-040 The bench SHALL force 300 rejections -> err_cnt=255, then pulse rst low mid-frame -> all outputs return to 0 and busy=0.
